// File: rtl/zone_double_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : zone_double_buffer
//  Description : Multi-zone dark-weight double buffer. Per-pixel darkness
//                weights are summed into ZONES saturating accumulators
//                (buffer B). On each frame-boundary freeze, a per-zone
//                dark/light decision and a saturation flag are committed to
//                held output registers (buffer A). The accumulators are
//                cleared on the same edge.
//                Optional feature macro: ZONE_BUF_HYST_EN
//                (adds a THRES_LO clear threshold for hysteresis).
//  Revision    : 1.0 - initial release
// ============================================================================
module zone_double_buffer #(
    parameter int ZONES    = 4,
    parameter int DEPTH    = 16,
    parameter int WD_W     = 3,
    parameter int THRES_HI = 0,
    parameter int THRES_LO = 0
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    freeze_i,
    input  logic                                    de_i,
    input  logic [((ZONES > 1) ? $clog2(ZONES) : 1)-1:0] zone_i,
    input  logic [WD_W-1:0]                         wd_i,
    output logic [ZONES-1:0]                        dark_o,
    output logic [ZONES-1:0]                        sat_o,
    output logic                                    valid_o,
    output logic                                    upd_o
);

    localparam int               c_ZW      = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam logic [DEPTH-1:0] c_ACC_MAX = '1;
    // Thresholds are compared at accumulator width, so they are truncated.
    localparam logic [DEPTH-1:0] c_THR_HI  = DEPTH'(THRES_HI);
`ifdef ZONE_BUF_HYST_EN
    localparam logic [DEPTH-1:0] c_THR_LO  = DEPTH'(THRES_LO);

    // An inverted hysteresis band would make the set/clear rules contradict.
    if (THRES_LO > THRES_HI) begin : g_thres_check
        $error("zone_double_buffer: THRES_LO must not exceed THRES_HI");
    end
`endif

    logic r_valid;
    logic r_upd;

    for (genvar z = 0; z < ZONES; z++) begin : g_zone
        logic [DEPTH-1:0] r_acc;
        logic             r_dark;
        logic             r_sat;
        logic             w_hit;
        logic [DEPTH:0]   w_sum;
        logic [DEPTH-1:0] w_acc_next;
        logic             w_dark_next;

        // Out-of-range zone indices never match any z, so they are dropped.
        assign w_hit      = de_i && (zone_i == c_ZW'(z));
        // One extra bit catches the carry so the sum can be clamped.
        assign w_sum      = {1'b0, r_acc} + {{(DEPTH + 1 - WD_W){1'b0}}, wd_i};
        assign w_acc_next = w_sum[DEPTH] ? c_ACC_MAX : w_sum[DEPTH-1:0];

`ifdef ZONE_BUF_HYST_EN
        assign w_dark_next = (r_acc > c_THR_HI) ? 1'b1 :
                             (r_acc < c_THR_LO) ? 1'b0 : r_dark;
`else
        assign w_dark_next = (r_acc > c_THR_HI);
`endif

        // Frame accumulator: freeze clears it and discards the freeze-cycle pixel.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_acc <= '0;
            end else if (freeze_i) begin
                r_acc <= '0;
            end else if (w_hit) begin
                r_acc <= w_acc_next;
            end
        end

        // Committed decision and saturation flag, held until the next freeze.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_dark <= 1'b0;
                r_sat  <= 1'b0;
            end else if (freeze_i) begin
                r_dark <= w_dark_next;
                r_sat  <= (r_acc == c_ACC_MAX);
            end
        end

        assign dark_o[z] = r_dark;
        assign sat_o[z]  = r_sat;
    end

    // Sticky valid flag and single-cycle update pulse following each freeze.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_upd   <= 1'b0;
        end else begin
            r_upd <= freeze_i;
            if (freeze_i) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign valid_o = r_valid;
    assign upd_o   = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_zone_double_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zone_double_buffer
//  Description : Self-checking bench for zone_double_buffer. Two instances
//                share the same stimulus: dut_a (4 zones, 16-bit, HI=20,
//                LO=10) and dut_b (3 zones, 4-bit, HI=0) so saturation and
//                out-of-range zone indices can both be exercised.
//                Honours ZONE_BUF_HYST_EN for the hysteresis expectation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zone_double_buffer;

    logic       clk_i;
    logic       rst_i;
    logic       freeze_i;
    logic       de_i;
    logic [1:0] zone_i;
    logic [2:0] wd_i;

    logic [3:0] dark_a, sat_a;
    logic       valid_a, upd_a;
    logic [2:0] dark_b, sat_b;
    logic       valid_b, upd_b;

    int n_tests;
    int n_fail;

    zone_double_buffer #(
        .ZONES(4), .DEPTH(16), .WD_W(3), .THRES_HI(20), .THRES_LO(10)
    ) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .freeze_i(freeze_i), .de_i(de_i),
        .zone_i(zone_i), .wd_i(wd_i),
        .dark_o(dark_a), .sat_o(sat_a), .valid_o(valid_a), .upd_o(upd_a)
    );

    zone_double_buffer #(
        .ZONES(3), .DEPTH(4), .WD_W(3), .THRES_HI(0), .THRES_LO(0)
    ) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .freeze_i(freeze_i), .de_i(de_i),
        .zone_i(zone_i), .wd_i(wd_i),
        .dark_o(dark_b), .sat_o(sat_b), .valid_o(valid_b), .upd_o(upd_b)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       freeze;
        logic       de;
        logic [1:0] zone;
        logic [2:0] wd;
        logic [3:0] dark_a;
        logic [3:0] sat_a;
        logic [2:0] dark_b;
        logic [2:0] sat_b;
        logic       valid;
        logic       upd;
    } vec_t;

    localparam int c_NVEC = 25;
`ifdef ZONE_BUF_HYST_EN
    localparam logic [3:0] c_MID_DARK = 4'b0001;
`else
    localparam logic [3:0] c_MID_DARK = 4'b0000;
`endif

    vec_t vecs [c_NVEC];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_dark_a, input logic [3:0] e_sat_a,
                             input logic [2:0] e_dark_b, input logic [2:0] e_sat_b,
                             input logic e_valid, input logic e_upd);
        check({tag, " dark_a"},  {4'b0, dark_a},  {4'b0, e_dark_a});
        check({tag, " sat_a"},   {4'b0, sat_a},   {4'b0, e_sat_a});
        check({tag, " dark_b"},  {5'b0, dark_b},  {5'b0, e_dark_b});
        check({tag, " sat_b"},   {5'b0, sat_b},   {5'b0, e_sat_b});
        check({tag, " valid_a"}, {7'b0, valid_a}, {7'b0, e_valid});
        check({tag, " valid_b"}, {7'b0, valid_b}, {7'b0, e_valid});
        check({tag, " upd_a"},   {7'b0, upd_a},   {7'b0, e_upd});
        check({tag, " upd_b"},   {7'b0, upd_b},   {7'b0, e_upd});
    endtask

    function automatic vec_t mk(input logic f, input logic d, input logic [1:0] z, input logic [2:0] w,
                                input logic [3:0] da, input logic [3:0] sa,
                                input logic [2:0] db, input logic [2:0] sb,
                                input logic v, input logic u);
        vec_t r;
        r.freeze = f; r.de = d; r.zone = z; r.wd = w;
        r.dark_a = da; r.sat_a = sa; r.dark_b = db; r.sat_b = sb;
        r.valid = v; r.upd = u;
        return r;
    endfunction

    task automatic drive(input logic f, input logic d, input logic [1:0] z, input logic [2:0] w);
        @(negedge clk_i);
        freeze_i = f; de_i = d; zone_i = z; wd_i = w;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_i    = 1'b1;
        freeze_i = 1'b0;
        de_i     = 1'b0;
        zone_i   = 2'd0;
        wd_i     = 3'd0;

        // Frame: zone1 21 (b: clamp 15), zone2 20 (b: clamp 15), zone3 21 (b: out of range)
        vecs[0]  = mk(0, 1, 2'd1, 3'd7, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 0);
        vecs[1]  = mk(0, 1, 2'd1, 3'd7, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 0);
        vecs[2]  = mk(0, 1, 2'd1, 3'd7, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 0);
        vecs[3]  = mk(0, 1, 2'd2, 3'd7, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 0);
        vecs[4]  = mk(0, 1, 2'd2, 3'd7, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 0);
        vecs[5]  = mk(0, 1, 2'd2, 3'd6, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 0);
        vecs[6]  = mk(0, 1, 2'd3, 3'd7, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 0);
        vecs[7]  = mk(0, 1, 2'd3, 3'd7, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 0);
        vecs[8]  = mk(0, 1, 2'd3, 3'd7, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 0);
        // Freeze with a live pixel on zone 0: pixel must be dropped
        vecs[9]  = mk(1, 1, 2'd0, 3'd7, 4'b1010, 4'b0000, 3'b110, 3'b110, 1, 1);
        vecs[10] = mk(0, 0, 2'd0, 3'd0, 4'b1010, 4'b0000, 3'b110, 3'b110, 1, 0);
        // Empty frame, then a back-to-back freeze
        vecs[11] = mk(1, 0, 2'd0, 3'd0, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 1);
        vecs[12] = mk(1, 0, 2'd0, 3'd0, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 1);
        // Zone 0 count 21 (b: 15 saturated)
        vecs[13] = mk(0, 1, 2'd0, 3'd7, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 0);
        vecs[14] = mk(0, 1, 2'd0, 3'd7, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 0);
        vecs[15] = mk(0, 1, 2'd0, 3'd7, 4'b0000, 4'b0000, 3'b000, 3'b000, 1, 0);
        vecs[16] = mk(1, 0, 2'd0, 3'd0, 4'b0001, 4'b0000, 3'b001, 3'b001, 1, 1);
        // Zone 0 count 15 (b: exactly 15, saturated without overflow)
        vecs[17] = mk(0, 1, 2'd0, 3'd7, 4'b0001, 4'b0000, 3'b001, 3'b001, 1, 0);
        vecs[18] = mk(0, 1, 2'd0, 3'd7, 4'b0001, 4'b0000, 3'b001, 3'b001, 1, 0);
        vecs[19] = mk(0, 1, 2'd0, 3'd1, 4'b0001, 4'b0000, 3'b001, 3'b001, 1, 0);
        vecs[20] = mk(1, 0, 2'd0, 3'd0, c_MID_DARK, 4'b0000, 3'b001, 3'b001, 1, 1);
        // Zone 0 count 9
        vecs[21] = mk(0, 1, 2'd0, 3'd7, c_MID_DARK, 4'b0000, 3'b001, 3'b001, 1, 0);
        vecs[22] = mk(0, 1, 2'd0, 3'd2, c_MID_DARK, 4'b0000, 3'b001, 3'b001, 1, 0);
        vecs[23] = mk(1, 0, 2'd0, 3'd0, 4'b0000, 4'b0000, 3'b001, 3'b000, 1, 1);
        vecs[24] = mk(0, 0, 2'd0, 3'd0, 4'b0000, 4'b0000, 3'b001, 3'b000, 1, 0);

        // Reset state
        @(posedge clk_i);
        #1;
        check_all("reset", 4'b0, 4'b0, 3'b0, 3'b0, 0, 0);

        @(negedge clk_i);
        rst_i = 1'b0;

        // Partial frame discarded by a mid-frame reset
        for (int i = 0; i < 10; i++) drive(0, 1, 2'd0, 3'd7);
        check_all("prefill", 4'b0, 4'b0, 3'b0, 3'b0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        de_i  = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(1, 0, 2'd0, 3'd0);
        check_all("rst_freeze", 4'b0, 4'b0, 3'b0, 3'b0, 1, 1);
        drive(0, 0, 2'd0, 3'd0);
        check_all("rst_after", 4'b0, 4'b0, 3'b0, 3'b0, 1, 0);

        // Table-driven frames
        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i].freeze, vecs[i].de, vecs[i].zone, vecs[i].wd);
            check_all($sformatf("vec%0d", i), vecs[i].dark_a, vecs[i].sat_a,
                      vecs[i].dark_b, vecs[i].sat_b, vecs[i].valid, vecs[i].upd);
        end

        // Reset must clear committed outputs without waiting for a clock edge
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_all("async_rst", 4'b0, 4'b0, 3'b0, 3'b0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
